// File: rtl/bldc_pkg.sv
// Shared definitions for the BLDC gate driver: phase FSM state encoding,
// phase index constants and the u/z command legality check.
package bldc_pkg;

  typedef logic [1:0] phase_state_t;

  // Phase FSM states; HI/LO double as the per-phase request codes
  localparam logic [1:0] ST_OFF  = 2'b00;
  localparam logic [1:0] ST_DEAD = 2'b01;
  localparam logic [1:0] ST_HI   = 2'b10;
  localparam logic [1:0] ST_LO   = 2'b11;

  // Bit positions of each phase in u/z/gate vectors
  localparam int unsigned PH_A   = 2;
  localparam int unsigned PH_B   = 1;
  localparam int unsigned PH_C   = 0;
  localparam int unsigned NUM_PH = 3;

  function automatic logic is_onehot3(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

  // Legal: one high phase, one floating phase, the third low; or full coast
  function automatic logic cmd_legal(input logic [2:0] u, input logic [2:0] z);
    logic drive_ok;
    logic coast_ok;
    drive_ok = is_onehot3(u) && is_onehot3(z) && ((u & z) == 3'b000);
    coast_ok = (u == 3'b000) && (z == 3'b111);
    return drive_ok || coast_ok;
  endfunction

endpackage

// File: rtl/bldc_phase_gate.sv
// One half-bridge: follows the OFF/HI/LO request with a dead-time interval
// inserted before any gate turns on, so both gates are never on together.
// Ports:
//   clk, rst  clock, async active-high reset
//   req       requested state (ST_OFF, ST_HI or ST_LO)
//   gate_h    registered high-side gate enable
//   gate_l    registered low-side gate enable
module bldc_phase_gate
  import bldc_pkg::*;
#(
  parameter int unsigned DEAD_CYCLES = 8,
  parameter int unsigned DEAD_BITS   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic       gate_h,
  output logic       gate_l
);

  phase_state_t         state;
  phase_state_t         state_nxt;
  logic [DEAD_BITS-1:0] dcnt;
  logic [DEAD_BITS-1:0] dcnt_nxt;

  // State and dead-time counter registers; gates decode the current state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_OFF;
      dcnt   <= '0;
      gate_h <= 1'b0;
      gate_l <= 1'b0;
    end else begin
      state  <= state_nxt;
      dcnt   <= dcnt_nxt;
      gate_h <= (state == ST_HI);
      gate_l <= (state == ST_LO);
    end
  end

  // Next state: turning off is immediate, turning on always passes through DEAD
  always_comb begin
    state_nxt = state;
    dcnt_nxt  = dcnt;
    case (state)
      ST_DEAD: begin
        // Request is only looked at on exit; changes during DEAD do not restart it
        if (dcnt == '0) begin
          state_nxt = (req == ST_DEAD) ? ST_OFF : req;
        end else begin
          dcnt_nxt = dcnt - DEAD_BITS'(1);
        end
      end
      default: begin
        if (req == ST_OFF || req == ST_DEAD) begin
          state_nxt = ST_OFF;
        end else if (req != state) begin
          state_nxt = ST_DEAD;
          dcnt_nxt  = DEAD_BITS'(DEAD_CYCLES - 1);
        end
      end
    endcase
  end

endmodule

// File: rtl/bldc_gate_driver.sv
// Three-phase gate driver fed by the hall commutation decoder. Registers the
// phase commands and duty, checks the command pattern, runs the PWM counter
// and drives three dead-time protected half-bridges.
// Ports:
//   clk, rst   clock, async active-high reset
//   enable     0 forces all gates off
//   u          high-phase command (bit2 = phase A)
//   z          high-impedance command (bit2 = phase A)
//   duty       high-side on-time per PWM period; >= 2**PWM_BITS is 100%
//   gate_h     high-side gate enables (bit2 = phase A)
//   gate_l     low-side gate enables (bit2 = phase A)
//   pwm_sync   one-clk pulse while the PWM counter is 0
//   cmd_fault  registered flag: current u/z pattern is illegal
module bldc_gate_driver
  import bldc_pkg::*;
#(
  parameter int unsigned PWM_BITS    = 10,
  parameter int unsigned DEAD_CYCLES = 8,
  parameter int unsigned DEAD_BITS   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [2:0]        u,
  input  logic [2:0]        z,
  input  logic [PWM_BITS:0] duty,
  output logic [2:0]        gate_h,
  output logic [2:0]        gate_l,
  output logic              pwm_sync,
  output logic              cmd_fault
);

  logic [2:0]          u_q;
  logic [2:0]          z_q;
  logic [PWM_BITS:0]   duty_q;
  logic [PWM_BITS-1:0] cnt;
  logic                legal_c;
  logic                pwm_on_c;

  // Reset z_q to all-floating so the reset command is a legal coast
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      u_q       <= 3'b000;
      z_q       <= 3'b111;
      duty_q    <= '0;
      cnt       <= '0;
      pwm_sync  <= 1'b0;
      cmd_fault <= 1'b0;
    end else begin
      u_q       <= u;
      z_q       <= z;
      duty_q    <= duty;
      cnt       <= cnt + PWM_BITS'(1);
      // Registered so that it is high in the same cycle cnt reads 0
      pwm_sync  <= (cnt == '1);
      cmd_fault <= ~legal_c;
    end
  end

  assign legal_c  = cmd_legal(u_q, z_q);
  // Extra duty bit lets full scale compare true on every count
  assign pwm_on_c = ({1'b0, cnt} < duty_q);

  for (genvar g = 0; g < NUM_PH; g++) begin : g_phase
    logic [1:0] req_c;

    // Per-phase request; the non-high driven phase is the complementary low side
    always_comb begin
      req_c = ST_OFF;
      if (enable && legal_c && !z_q[g]) begin
        if (u_q[g]) begin
          req_c = pwm_on_c ? ST_HI : ST_LO;
        end else begin
          req_c = ST_LO;
        end
      end
    end

    bldc_phase_gate #(
      .DEAD_CYCLES(DEAD_CYCLES),
      .DEAD_BITS  (DEAD_BITS)
    ) u_phase_gate (
      .clk   (clk),
      .rst   (rst),
      .req   (req_c),
      .gate_h(gate_h[g]),
      .gate_l(gate_l[g])
    );
  end

endmodule

// File: tb/tb_bldc_gate_driver.sv
// Self-checking bench for bldc_gate_driver: a cycle model of the gate rules
// compared every cycle, directed scenarios with hand-derived expectations,
// then randomized commands, duties, enables and resets.
module tb_bldc_gate_driver;

  localparam int PWM_BITS    = 10;
  localparam int DEAD_CYCLES = 8;
  localparam int DEAD_BITS   = 4;
  localparam int PERIOD      = 1 << PWM_BITS;

  logic          clk    = 1'b0;
  logic          rst    = 1'b1;
  logic          enable = 1'b0;
  logic [2:0]    u      = 3'b000;
  logic [2:0]    z      = 3'b111;
  logic [PWM_BITS:0] duty = '0;
  logic [2:0]    gate_h;
  logic [2:0]    gate_l;
  logic          pwm_sync;
  logic          cmd_fault;

  int tests = 0;
  int fails = 0;

  bldc_gate_driver #(
    .PWM_BITS   (PWM_BITS),
    .DEAD_CYCLES(DEAD_CYCLES),
    .DEAD_BITS  (DEAD_BITS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .u        (u),
    .z        (z),
    .duty     (duty),
    .gate_h   (gate_h),
    .gate_l   (gate_l),
    .pwm_sync (pwm_sync),
    .cmd_fault(cmd_fault)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Each phase is "off", "high", "low" or "waiting" with a count of remaining
  // dead cycles; the gate outputs show what the phase did one cycle earlier.
  localparam int M_OFF = 0, M_HIGH = 1, M_LOW = 2, M_WAIT = 3;

  logic [2:0] m_u = 3'b000;
  logic [2:0] m_z = 3'b111;
  int         m_duty = 0;
  int         m_cnt = 0;
  int         m_mode [3];
  int         m_left [3];
  logic [2:0] exp_h = 3'b000;
  logic [2:0] exp_l = 3'b000;
  logic       exp_sync = 1'b0;
  logic       exp_fault = 1'b0;

  function automatic bit legal(input logic [2:0] uu, input logic [2:0] zz);
    return ($countones(uu) == 1 && $countones(zz) == 1 && (uu & zz) == 3'b000) ||
           (uu == 3'b000 && zz == 3'b111);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_u = 3'b000; m_z = 3'b111; m_duty = 0; m_cnt = 0;
      exp_h = 3'b000; exp_l = 3'b000; exp_sync = 1'b0; exp_fault = 1'b0;
      for (int n = 0; n < 3; n++) begin
        m_mode[n] = M_OFF;
        m_left[n] = 0;
      end
    end else begin
      bit on;
      bit ok;
      on = (m_cnt < m_duty);
      ok = legal(m_u, m_z);
      for (int n = 0; n < 3; n++) begin
        int want;
        exp_h[n] = (m_mode[n] == M_HIGH);
        exp_l[n] = (m_mode[n] == M_LOW);
        if (!enable || !ok || m_z[n]) want = M_OFF;
        else if (m_u[n]) want = on ? M_HIGH : M_LOW;
        else want = M_LOW;
        if (m_mode[n] == M_WAIT) begin
          if (m_left[n] == 0) m_mode[n] = want;
          else m_left[n] = m_left[n] - 1;
        end else if (want == M_OFF) begin
          m_mode[n] = M_OFF;
        end else if (want != m_mode[n]) begin
          m_mode[n] = M_WAIT;
          m_left[n] = DEAD_CYCLES - 1;
        end
      end
      exp_fault = !ok;
      exp_sync  = (m_cnt == PERIOD - 1);
      m_cnt     = (m_cnt + 1) % PERIOD;
      m_u       = u;
      m_z       = z;
      m_duty    = int'(duty);
    end
  end

  // Every-cycle comparison against the model plus the shoot-through check
  always @(negedge clk) begin
    tests++;
    if ({gate_h, gate_l, pwm_sync, cmd_fault} !== {exp_h, exp_l, exp_sync, exp_fault}) begin
      fails++;
      if (fails < 40)
        $display("FAIL model t=%0t got h=%b l=%b sync=%b fault=%b expected h=%b l=%b sync=%b fault=%b",
                 $time, gate_h, gate_l, pwm_sync, cmd_fault, exp_h, exp_l, exp_sync, exp_fault);
    end
    tests++;
    if ((gate_h & gate_l) !== 3'b000) begin
      fails++;
      if (fails < 40)
        $display("FAIL shoot_through t=%0t got h=%b l=%b expected no overlap", $time, gate_h, gate_l);
    end
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  logic [2:0] su [6] = '{3'b100, 3'b100, 3'b010, 3'b010, 3'b001, 3'b001};
  logic [2:0] sz [6] = '{3'b010, 3'b001, 3'b100, 3'b001, 3'b100, 3'b010};

  initial begin
    int hc, lc, sc, last;

    // Reset with random inputs
    rst = 1'b1;
    repeat (4) begin
      u = 3'($urandom); z = 3'($urandom); duty = 11'($urandom); enable = 1'($urandom);
      step();
    end
    chk("reset_gate_h", int'(gate_h), 0);
    chk("reset_gate_l", int'(gate_l), 0);
    chk("reset_fault", int'(cmd_fault), 0);
    chk("reset_sync", int'(pwm_sync), 0);

    // Commutation A+C- -> B+A-, full-scale duty
    enable = 1'b1; duty = 11'd1024; u = 3'b100; z = 3'b010; rst = 1'b0;
    run(30);
    chk("steady_h", int'(gate_h), 3'b100);
    chk("steady_l", int'(gate_l), 3'b001);
    u = 3'b010; z = 3'b001;
    for (int k = 1; k <= 14; k++) begin
      step();
      chk($sformatf("c1_a_h_e%0d", k), int'(gate_h[2]), int'(k < 3));
      chk($sformatf("c1_b_h_e%0d", k), int'(gate_h[1]), int'(k >= 3 + DEAD_CYCLES));
      chk($sformatf("c1_a_l_e%0d", k), int'(gate_l[2]), int'(k >= 3 + DEAD_CYCLES));
      chk($sformatf("c1_c_l_e%0d", k), int'(gate_l[0]), int'(k < 3));
    end

    // Commutation A+C- -> B+C-: low side of C held throughout
    u = 3'b100; z = 3'b010; run(30);
    u = 3'b010; z = 3'b100;
    for (int k = 1; k <= 14; k++) begin
      step();
      chk($sformatf("c2_c_l_e%0d", k), int'(gate_l[0]), 1);
      chk($sformatf("c2_a_h_e%0d", k), int'(gate_h[2]), int'(k < 3));
      chk($sformatf("c2_b_h_e%0d", k), int'(gate_h[1]), int'(k >= 3 + DEAD_CYCLES));
    end

    // PWM at quarter duty
    duty = 11'd256; u = 3'b100; z = 3'b001;
    run(1100);
    hc = 0; lc = 0; sc = 0; last = -1;
    for (int i = 0; i < 2 * PERIOD; i++) begin
      step();
      if (i < PERIOD) begin
        hc += int'(gate_h[2]);
        lc += int'(gate_l[2]);
      end
      if (pwm_sync) begin
        sc++;
        if (last >= 0) chk("sync_period", i - last, PERIOD);
        last = i;
      end
    end
    chk("pwm_high_count", hc, 256 - DEAD_CYCLES);
    chk("pwm_low_count", lc, PERIOD - 256 - DEAD_CYCLES);
    chk("sync_pulses", sc, 2);

    // Duty limits
    duty = 11'd0; run(30);
    hc = 0; lc = 0;
    for (int i = 0; i < 1100; i++) begin step(); hc += int'(gate_h[2]); lc += int'(gate_l[2]); end
    chk("duty0_high", hc, 0);
    chk("duty0_low", lc, 1100);
    duty = 11'd1024; run(30);
    hc = 0; lc = 0;
    for (int i = 0; i < 1100; i++) begin step(); hc += int'(gate_h[2]); lc += int'(gate_l[2]); end
    chk("duty_full_high", hc, 1100);
    chk("duty_full_low", lc, 0);

    // Illegal command patterns
    u = 3'b100; z = 3'b010; run(30);
    u = 3'b110; z = 3'b001; run(3);
    chk("ill1_fault", int'(cmd_fault), 1);
    chk("ill1_gates", int'({gate_h, gate_l}), 0);
    u = 3'b100; z = 3'b010; run(30);
    chk("legal_fault", int'(cmd_fault), 0);
    chk("legal_gates", int'({gate_h, gate_l}), 6'b100001);
    u = 3'b000; z = 3'b000; run(3);
    chk("ill2_fault", int'(cmd_fault), 1);
    chk("ill2_gates", int'({gate_h, gate_l}), 0);

    // Enable dropped while phase B is in dead time
    u = 3'b100; z = 3'b010; run(30);
    u = 3'b010; z = 3'b100; run(5);
    enable = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k >= 2) chk($sformatf("en_off_e%0d", k), int'({gate_h, gate_l}), 0);
    end
    enable = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      step();
      chk($sformatf("en_rise_e%0d", k), int'({gate_h, gate_l}), (k >= 2 + DEAD_CYCLES) ? 6'b010001 : 0);
    end

    // Reset asserted while phase B is in dead time
    u = 3'b100; z = 3'b010; run(30);
    u = 3'b010; z = 3'b100; run(5);
    rst = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("rst_mid_e%0d", k), int'({gate_h, gate_l}), 0);
    end
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk($sformatf("rst_rise_e%0d", k), int'({gate_h, gate_l}), (k >= 3 + DEAD_CYCLES) ? 6'b010001 : 0);
    end

    // Randomized traffic checked by the model
    repeat (200) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 6) begin u = su[r]; z = sz[r]; end
      else if (r == 6) begin u = 3'b000; z = 3'b111; end
      else if (r == 7) begin u = 3'($urandom); z = 3'($urandom); end
      else begin r = $urandom_range(0, 5); u = su[r]; z = sz[r]; end
      case ($urandom_range(0, 4))
        0: duty = 11'd0;
        1: duty = 11'd1024;
        2: duty = 11'($urandom_range(1024, 2047));
        default: duty = 11'($urandom_range(0, 1023));
      endcase
      enable = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end
      run($urandom_range(1, 40));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
